stream_loader: RTL and testbench

STREAM_LOADER -- requirements
Module: stream_loader

---
 rtl/loader_pkg.sv | 34 +++
 rtl/onehot_to_idx.sv | 31 +++
 rtl/stream_loader.sv | 154 +++++++++++++++
 tb/tb_stream_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared sizing, helper functions and FSM state encoding for the stream loader.
// Pure declarations: no latency, no flow control.
package loader_pkg;

    localparam int N = 3;
    localparam int M = 2;

    function automatic int stream_len(input int n, input int m);
        return n + n * m + m;
    endfunction

    // Cycles the classifier needs after the last word before maxpo is stable.
    function automatic int lat_wait(input int n, input int m);
        return 2 * n * m + 2 * m + 1;
    endfunction

    function automatic int cls_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int L        = stream_len(N, M);
    localparam int LAT_WAIT = lat_wait(N, M);
    localparam int CLS_W    = cls_width(M);

    typedef enum logic [2:0] {
        IDLE,
        PRE1,
        PRE2,
        STREAM,
        COMPUTE,
        CAPTURE
    } state_t;

endpackage

// File: rtl/onehot_to_idx.sv
// One-hot vector to binary index (lowest set bit wins) plus "not exactly one bit" flag.
// Combinational, zero latency; no flow control.
module onehot_to_idx
    import loader_pkg::*;
#(
    parameter int M     = 2,
    parameter int CLS_W = 1
) (
    input  logic [M-1:0]     i_onehot,
    output logic [CLS_W-1:0] o_idx,
    output logic             o_err
);

    int w_cnt;

    always_comb begin
        o_idx = '0;
        w_cnt = 0;
        // Scan from the top so the lowest set bit is the last assignment.
        for (int i = M - 1; i >= 0; i--) begin
            if (i_onehot[i]) begin
                o_idx = CLS_W'(i);
            end
        end
        for (int i = 0; i < M; i++) begin
            w_cnt = w_cnt + int'(i_onehot[i]);
        end
        o_err = (w_cnt != 1);
    end

endmodule

// File: rtl/stream_loader.sv
// Streams N features, N*M weights and M biases from memory into the classifier, then captures its one-hot result.
// done arrives 2 + L + LAT_WAIT cycles after start is accepted; start is ignored while busy, there is no backpressure.
module stream_loader
    import loader_pkg::*;
#(
    parameter int N  = 3,
    parameter int M  = 2,
    parameter int AW = 16,
    localparam int CLS_W = cls_width(M)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    output logic             mem_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic             cls_reset,
    output logic [31:0]      data_out,
    input  logic [M-1:0]     maxpo,
    output logic [CLS_W-1:0] class_idx,
    output logic             result_valid,
    output logic             onehot_err,
    output logic             busy,
    output logic             done
);

    localparam int SLEN = stream_len(N, M);
    localparam int WLEN = lat_wait(N, M);
    localparam int CW   = $clog2(SLEN + 1);
    localparam int WCW  = $clog2(WLEN + 1);

    state_t           r_state;
    logic             r_mem_en;
    logic [AW-1:0]    r_addr;
    logic [CW-1:0]    r_iss;
    logic [CW-1:0]    r_word;
    logic [WCW-1:0]   r_wait;
    logic             r_cls_reset;
    logic [31:0]      r_data;
    logic [CLS_W-1:0] r_idx;
    logic             r_valid;
    logic             r_err;
    logic             r_busy;
    logic             r_done;

    logic [CLS_W-1:0] w_idx;
    logic             w_err;

    onehot_to_idx #(
        .M     (M),
        .CLS_W (CLS_W)
    ) u_onehot_to_idx (
        .i_onehot (maxpo),
        .o_idx    (w_idx),
        .o_err    (w_err)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mem_en    <= 1'b0;
            r_addr      <= '0;
            r_iss       <= '0;
            r_word      <= '0;
            r_wait      <= '0;
            r_cls_reset <= 1'b1;
            r_data      <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Address issue runs one word ahead of the data path and stops after the last word.
            if (r_mem_en) begin
                if (r_iss < CW'(SLEN)) begin
                    r_addr <= r_addr + AW'(1);
                    r_iss  <= r_iss + CW'(1);
                end else begin
                    r_mem_en <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= PRE1;
                        r_busy   <= 1'b1;
                        r_valid  <= 1'b0;
                        r_mem_en <= 1'b1;
                        r_addr   <= base_addr;
                        r_iss    <= CW'(1);
                        r_word   <= '0;
                        r_wait   <= '0;
                    end
                end
                PRE1: begin
                    r_state <= PRE2;
                end
                PRE2: begin
                    r_data      <= mem_rdata;
                    r_cls_reset <= 1'b0;
                    r_state     <= STREAM;
                end
                STREAM: begin
                    if (r_word == CW'(SLEN - 1)) begin
                        r_data  <= '0;
                        r_wait  <= '0;
                        r_state <= COMPUTE;
                    end else begin
                        r_data <= mem_rdata;
                        r_word <= r_word + CW'(1);
                    end
                end
                COMPUTE: begin
                    if (r_wait == WCW'(WLEN - 1)) begin
                        r_idx   <= w_idx;
                        r_err   <= w_err;
                        r_valid <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= CAPTURE;
                    end else begin
                        r_wait <= r_wait + WCW'(1);
                    end
                end
                CAPTURE: begin
                    r_cls_reset <= 1'b1;
                    r_busy      <= 1'b0;
                    r_iss       <= '0;
                    r_word      <= '0;
                    r_wait      <= '0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en       = r_mem_en;
    assign mem_addr     = r_addr;
    assign cls_reset    = r_cls_reset;
    assign data_out     = r_data;
    assign class_idx    = r_idx;
    assign result_valid = r_valid;
    assign onehot_err   = r_err;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_stream_loader.sv
// Directed bench for stream_loader: memory model with 1-cycle read latency, classifier result driven directly on maxpo.
module tb_stream_loader;

    localparam int N    = 3;
    localparam int M    = 2;
    localparam int AW   = 16;
    localparam int L    = 11;
    localparam int LATW = 17;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        cls_reset;
    logic [31:0] data_out;
    logic [1:0]  maxpo;
    logic [0:0]  class_idx;
    logic        result_valid;
    logic        onehot_err;
    logic        busy;
    logic        done;

    logic [31:0] mem   [0:65535];
    logic [31:0] exp_w [0:L-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    stream_loader #(.N(N), .M(M), .AW(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .cls_reset    (cls_reset),
        .data_out     (data_out),
        .maxpo        (maxpo),
        .class_idx    (class_idx),
        .result_valid (result_valid),
        .onehot_err   (onehot_err),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Features 1.0, 2.0, 3.0; all weights 1.0; biases b0, b1.
    task automatic load(input logic [15:0] base, input logic [31:0] b0, input logic [31:0] b1);
        exp_w[0] = 32'h3F80_0000;
        exp_w[1] = 32'h4000_0000;
        exp_w[2] = 32'h4040_0000;
        for (int i = 3; i < 9; i++) exp_w[i] = 32'h3F80_0000;
        exp_w[9]  = b0;
        exp_w[10] = b1;
        for (int i = 0; i < L; i++) mem[base + 16'(i)] = exp_w[i];
    endtask

    task automatic run(input logic [15:0] base, input logic [1:0] mp, input logic [0:0] want_idx,
                       input logic want_err, input bit inject);
        int          cyc;
        int          ndone;
        logic [15:0] a;
        base_addr = base;
        maxpo     = mp;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        chk("pre1_en", 32'(mem_en), 32'd1);
        chk("pre1_addr", 32'(mem_addr), 32'(base));
        chk("pre1_busy", 32'(busy), 32'd1);
        chk("pre1_clsrst", 32'(cls_reset), 32'd1);
        chk("pre1_valid_clr", 32'(result_valid), 32'd0);
        @(negedge clk) cyc++;
        a = base + 16'd1;
        chk("pre2_addr", 32'(mem_addr), 32'(a));
        chk("pre2_clsrst", 32'(cls_reset), 32'd1);
        for (int k = 0; k < L; k++) begin
            @(negedge clk) cyc++;
            chk($sformatf("word%0d", k), data_out, exp_w[k]);
            chk($sformatf("clsrst_w%0d", k), 32'(cls_reset), 32'd0);
            chk($sformatf("en_w%0d", k), 32'(mem_en), (k <= L - 3) ? 32'd1 : 32'd0);
            if (k <= L - 3) begin
                a = base + 16'(k + 2);
                chk($sformatf("addr_w%0d", k), 32'(mem_addr), 32'(a));
            end
            if (inject && k == 4) start = 1'b1;
            if (inject && k == 5) start = 1'b0;
        end
        @(negedge clk) cyc++;
        chk("post_data", data_out, 32'd0);
        chk("post_en", 32'(mem_en), 32'd0);
        while (!done && cyc < 100) begin
            @(negedge clk) cyc++;
            if (inject && cyc == 20) start = 1'b1;
            if (inject && cyc == 21) start = 1'b0;
        end
        chk("done_cycle", 32'(cyc), 32'(2 + L + LATW));
        chk("class_idx", 32'(class_idx), 32'(want_idx));
        chk("onehot_err", 32'(onehot_err), 32'(want_err));
        chk("valid", 32'(result_valid), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_clsrst", 32'(cls_reset), 32'd1);
        chk("valid_hold", 32'(result_valid), 32'd1);
        chk("idx_hold", 32'(class_idx), 32'(want_idx));
        if (inject) begin
            ndone = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("extra_done", 32'(ndone), 32'd0);
            chk("stay_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        maxpo     = '0;
        repeat (3) @(negedge clk);
        chk("rst_clsrst", 32'(cls_reset), 32'd1);
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_idx", 32'(class_idx), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_err", 32'(onehot_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_clsrst0", 32'(cls_reset), 32'd1);

        // Scores 6 and 7: class 1 wins.
        load(16'h0000, 32'h0000_0000, 32'h3F80_0000);
        run(16'h0000, 2'b10, 1'b1, 1'b0, 1'b0);

        // Scores 8 and 6: class 0 wins.
        load(16'h0000, 32'h4000_0000, 32'h0000_0000);
        run(16'h0000, 2'b01, 1'b0, 1'b0, 1'b0);

        run(16'h0000, 2'b11, 1'b0, 1'b1, 1'b0);
        run(16'h0000, 2'b00, 1'b0, 1'b1, 1'b1);

        // Abort at stream word 5.
        maxpo = 2'b01;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_word5", data_out, exp_w[5]);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_clsrst", 32'(cls_reset), 32'd1);
        chk("abort_en", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data", data_out, 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd0);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run(16'h0000, 2'b01, 1'b0, 1'b0, 1'b0);

        // Address wrap 0xFFFC..0x0006.
        load(16'hFFFC, 32'h0000_0000, 32'h3F80_0000);
        run(16'hFFFC, 2'b10, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
